// File: rtl/spi_pkg.sv
// Shared SPI definitions for the RX and TX FIFO blocks.
// SPI_RX_LSB_FIRST_EN selects LSB-first assembly of received bytes.
package spi_pkg;

    localparam int SPI_BYTE_W     = 8;
    localparam int SPI_FIFO_DEPTH = 16;

    typedef enum logic {
        RX_IDLE,
        RX_SHIFT
    } rx_state_t;

    // Next shift-register value given the current byte and one MISO bit.
    function automatic logic [SPI_BYTE_W-1:0] rx_shift_in(
        input logic [SPI_BYTE_W-1:0] sr,
        input logic                  b
    );
`ifdef SPI_RX_LSB_FIRST_EN
        return {b, sr[SPI_BYTE_W-1:1]};
`else
        return {sr[SPI_BYTE_W-2:0], b};
`endif
    endfunction

endpackage

// File: rtl/spi_rx_shifter.sv
// Oversampled SPI mode-0 receive shifter: synchronisers, SCK edge
// detect, bit counter and byte assembly (order set in spi_pkg).
module spi_rx_shifter
    import spi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_cs,
    input  logic                  sck,
    input  logic                  miso,
    output logic [SPI_BYTE_W-1:0] rx_byte,
    output logic                  byte_done
);

    logic [1:0]            sck_sync;
    logic [1:0]            miso_sync;
    logic [1:0]            cs_sync;
    logic                  sck_d;
    logic [1:0]            warm;
    logic                  cs_armed;
    rx_state_t             state_q;
    rx_state_t             state_d;
    logic [2:0]            bit_cnt;
    logic [SPI_BYTE_W-1:0] shreg;
    logic                  sync_sck;
    logic                  sync_miso;
    logic                  sync_cs;
    logic                  sck_rise;
    logic                  shift_en;

    assign sync_sck  = sck_sync[1];
    assign sync_miso = miso_sync[1];
    assign sync_cs   = cs_sync[1];
    assign sck_rise  = sync_sck & ~sck_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_sync  <= '0;
            miso_sync <= '0;
            cs_sync   <= '0;
            sck_d     <= 1'b0;
            warm      <= '0;
        end else begin
            sck_sync  <= {sck_sync[0], sck};
            miso_sync <= {miso_sync[0], miso};
            cs_sync   <= {cs_sync[0], spi_cs};
            sck_d     <= sync_sck;
            warm      <= {warm[0], 1'b1};
        end
    end

    // A real low CS sample is required after reset before any capture,
    // so a transfer cut by reset is never resumed mid-byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_armed <= 1'b0;
        end else if (warm[1] && !sync_cs) begin
            cs_armed <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (sync_cs && cs_armed) begin
                    state_d = RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                if (!sync_cs) begin
                    state_d = RX_IDLE;
                end else begin
                    shift_en = sck_rise;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RX_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == RX_IDLE || !sync_cs) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= rx_shift_in(shreg, sync_miso);
            end
        end
    end

    assign rx_byte   = rx_shift_in(shreg, sync_miso);
    assign byte_done = shift_en && (bit_cnt == 3'd7);

endmodule

// File: rtl/spi_miso_rx_fifo.sv
// SPI MISO receiver with byte FIFO and read-enable/valid read port.
// SPI_RX_LSB_FIRST_EN (optional) reverses the received bit order.
module spi_miso_rx_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = SPI_FIFO_DEPTH,
    parameter int ASIZE = 4,
    parameter int DSIZE = SPI_BYTE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_cs,
    input  logic             sck,
    input  logic             miso,
    input  logic             rd_en,
    input  logic             clr_ovf,
    output logic [DSIZE-1:0] rdata,
    output logic             rd_valid,
    output logic             empty,
    output logic             full,
    output logic [ASIZE:0]   count,
    output logic             overflow
);

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE:0]   wptr;
    logic [ASIZE:0]   rptr;
    logic [DSIZE-1:0] rx_byte;
    logic             byte_done;
    logic             pop;
    logic             push_ok;
    logic             drop;

    spi_rx_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .spi_cs    (spi_cs),
        .sck       (sck),
        .miso      (miso),
        .rx_byte   (rx_byte),
        .byte_done (byte_done)
    );

    assign empty = (wptr == rptr);
    assign full  = (wptr[ASIZE] != rptr[ASIZE]) &&
                   (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
    assign count = wptr - rptr;

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign pop     = rd_en && !empty;
    assign push_ok = byte_done && (!full || pop);
    assign drop    = byte_done && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr[ASIZE-1:0]] <= rx_byte;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (pop) begin
                rdata <= mem[rptr[ASIZE-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_miso_rx_fifo.sv
// Self-checking bench for spi_miso_rx_fifo: directed steps plus random
// traffic against a queue-based model of the receive FIFO.
module tb_spi_miso_rx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       spi_cs = 1'b0;
    logic       sck = 1'b0;
    logic       miso = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] rdata;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;

    int checks = 0;
    int failures = 0;

    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    logic [7:0] m_last = 8'h00;

    spi_miso_rx_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .spi_cs   (spi_cs),
        .sck      (sck),
        .miso     (miso),
        .rd_en    (rd_en),
        .clr_ovf  (clr_ovf),
        .rdata    (rdata),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic wire_bit(input logic [7:0] b, input int i);
`ifdef SPI_RX_LSB_FIRST_EN
        return b[i];
`else
        return b[7-i];
`endif
    endfunction

    function automatic void model_push(input logic [7:0] b);
        if (mq.size() < 16) mq.push_back(b);
        else m_ovf = 1'b1;
    endfunction

    task automatic send_bit(input logic b);
        miso = b;
        repeat (4) tick();
        sck = 1'b1;
        repeat (4) tick();
        sck = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) send_bit(wire_bit(b, i));
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
        model_push(b);
    endtask

    task automatic cs_set(input logic v);
        spi_cs = v;
        repeat (4) tick();
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(count), 32'(mq.size()));
        check({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
        check({tag, ".full"}, 32'(full), 32'(mq.size() == 16));
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic do_read(input string tag);
        logic       exp_v;
        logic [7:0] exp_d;
        exp_v = (mq.size() > 0);
        if (exp_v) m_last = mq.pop_front();
        exp_d = m_last;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check({tag, ".valid"}, 32'(rd_valid), 32'(exp_v));
        check({tag, ".rdata"}, 32'(rdata), 32'(exp_d));
    endtask

    initial begin
        logic [7:0] seq;
        logic [7:0] rb;
        int r;

        repeat (3) tick();
        check("rst.rdata", 32'(rdata), 32'h0);
        check("rst.valid", 32'(rd_valid), 32'h0);
        check_state("rst");
        rst = 1'b1;
        repeat (4) tick();

        do_read("rd_empty");

        // 0xA5: empty must fall exactly one cycle after the 8th edge
        cs_set(1'b1);
        send_bits(8'hA5, 7);
        miso = wire_bit(8'hA5, 7);
        repeat (4) tick();
        sck = 1'b1;
        tick();
        tick();
        check("a5.empty_pre", 32'(empty), 32'h1);
        tick();
        check("a5.empty_post", 32'(empty), 32'h0);
        model_push(8'hA5);
        repeat (3) tick();
        sck = 1'b0;
        repeat (4) tick();
        do_read("a5");

        // aborted partial byte followed by a full byte
        send_bits(8'h3C, 5);
        cs_set(1'b0);
        cs_set(1'b1);
        send_byte(8'h81);
        check_state("abort");
        do_read("abort_rd");
        check_state("abort_drain");

        // overflow: 17 bytes into 16 slots
        for (int i = 0; i < 17; i++) begin
            send_byte(8'(i));
            if (i == 15) check_state("fill16");
        end
        check_state("ovf");
        for (int i = 0; i < 16; i++) do_read("ovf_rd");
        check_state("ovf_drain");
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        m_ovf = 1'b0;
        check_state("clr_ovf");

        // full FIFO: push of the 17th byte coincides with a pop
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        check_state("full_again");
        send_bits(8'h10, 7);
        miso = wire_bit(8'h10, 7);
        repeat (4) tick();
        sck = 1'b1;
        tick();
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        m_last = mq.pop_front();
        mq.push_back(8'h10);
        check("coin.valid", 32'(rd_valid), 32'h1);
        check("coin.rdata", 32'(rdata), 32'h00);
        check_state("coin");
        repeat (3) tick();
        sck = 1'b0;
        repeat (4) tick();
        while (mq.size() > 0) do_read("coin_drain");
        check_state("coin_empty");

        // wire-order bits 1,0,1,0,0,1,0,1 decode to 0xA5 in either order
        seq = 8'b1010_0101;
        for (int i = 0; i < 8; i++) send_bit(seq[7-i]);
        model_push(8'hA5);
        do_read("bitseq");

        // reset mid-byte, with CS held high afterwards
        send_bits(8'hF0, 4);
        rst = 1'b0;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        m_last = 8'h00;
        check("mid_rst.rdata", 32'(rdata), 32'h0);
        check("mid_rst.valid", 32'(rd_valid), 32'h0);
        check_state("mid_rst");
        repeat (2) tick();
        rst = 1'b1;
        repeat (4) tick();
        send_bits(8'hF0, 4);
        send_bits(8'h77, 8);
        check_state("no_resume");
        cs_set(1'b0);
        cs_set(1'b1);
        send_byte(8'h5A);
        check_state("post_rst");
        do_read("post_rst_rd");

        // random traffic
        for (int k = 0; k < 60; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                rb = 8'($urandom);
                send_byte(rb);
            end else if (r < 9) begin
                do_read("rnd_rd");
            end else begin
                clr_ovf = 1'b1;
                tick();
                clr_ovf = 1'b0;
                m_ovf = 1'b0;
            end
            check_state("rnd");
        end
        while (mq.size() > 0) do_read("rnd_drain");
        check_state("rnd_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
